// File: rtl/vga_gen_if.sv
// Timing-set offer channel for vga_gen: valid/ready handshake, rejection pulse and
// the eight per-axis timing values (visible size, sync start, sync stop, total).
interface vga_gen_if #(
   parameter int WIDTH = 11
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_err;
   logic [WIDTH-1:0] cfg_hsize;
   logic [WIDTH-1:0] cfg_hfp;
   logic [WIDTH-1:0] cfg_hsp;
   logic [WIDTH-1:0] cfg_hmax;
   logic [WIDTH-1:0] cfg_vsize;
   logic [WIDTH-1:0] cfg_vfp;
   logic [WIDTH-1:0] cfg_vsp;
   logic [WIDTH-1:0] cfg_vmax;

   modport master (
      output cfg_valid, cfg_hsize, cfg_hfp, cfg_hsp, cfg_hmax,
             cfg_vsize, cfg_vfp, cfg_vsp, cfg_vmax,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_hsize, cfg_hfp, cfg_hsp, cfg_hmax,
             cfg_vsize, cfg_vfp, cfg_vsp, cfg_vmax,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/vga_gen.sv
// VGA timing generator with a shadowed timing set that is swapped in only at frame end.
// Define VGA_GEN_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_gen #(
   parameter int WIDTH = 11,
   parameter int HSPP  = 0,
   parameter int VSPP  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   vga_gen_if.slave         cfg,
   output logic [WIDTH-1:0] hdata,
   output logic [WIDTH-1:0] vdata,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             line_start,
   output logic             frame_start,
   output logic             running
`ifdef VGA_GEN_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] hsize, hfp, hsp, hmax, vsize, vfp, vsp, vmax;
   } timing_t;

   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic             HS_ON = (HSPP != 0);
   localparam logic             VS_ON = (VSPP != 0);

   state_t           state, state_nx;
   timing_t          act, shd, offer;
   logic [WIDTH-1:0] hcnt, vcnt;
   logic             err_q, ready;
   logic             xfer, legal, active, h_last, v_last, frame_end;
   logic             load_act, load_shd, swap, reject;

   always_comb begin
      offer.hsize = cfg.cfg_hsize;
      offer.hfp   = cfg.cfg_hfp;
      offer.hsp   = cfg.cfg_hsp;
      offer.hmax  = cfg.cfg_hmax;
      offer.vsize = cfg.cfg_vsize;
      offer.vfp   = cfg.cfg_vfp;
      offer.vsp   = cfg.cfg_vsp;
      offer.vmax  = cfg.cfg_vmax;
   end

   assign ready = (state != PEND);
   assign xfer  = cfg.cfg_valid && ready;
   assign legal = (offer.hsize <= offer.hfp) && (offer.hfp <= offer.hsp) &&
                  (offer.hsp <= offer.hmax) && (offer.hmax > ONE) &&
                  (offer.vsize <= offer.vfp) && (offer.vfp <= offer.vsp) &&
                  (offer.vsp <= offer.vmax) && (offer.vmax > ONE);

   assign active    = (state != IDLE);
   assign h_last    = (hcnt == act.hmax - ONE);
   assign v_last    = (vcnt == act.vmax - ONE);
   assign frame_end = active && en && h_last && v_last;

   always_comb begin
      state_nx = state;
      load_act = '0;
      load_shd = '0;
      swap     = '0;
      reject   = '0;
      case (state)
         IDLE: if (xfer) begin
            if (legal) begin
               state_nx = RUN;
               load_act = '1;
            end else begin
               reject = '1;
            end
         end
         RUN: if (xfer) begin
            if (legal) begin
               state_nx = PEND;
               load_shd = '1;
            end else begin
               reject = '1;
            end
         end
         PEND: if (frame_end) begin
            state_nx = RUN;
            swap     = '1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Counters wrap to 0/0 on the frame-end cycle, so a swapped-in set starts on a clean frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         act   <= '0;
         shd   <= '0;
         hcnt  <= '0;
         vcnt  <= '0;
         err_q <= '0;
      end else begin
         state <= state_nx;
         err_q <= reject;
         if (load_act) begin
            act <= offer;
         end else if (swap) begin
            act <= shd;
         end
         if (load_shd) begin
            shd <= offer;
         end
         if (active && en) begin
            if (h_last) begin
               hcnt <= '0;
               vcnt <= v_last ? '0 : vcnt + ONE;
            end else begin
               hcnt <= hcnt + ONE;
            end
         end
      end
   end

   assign cfg.cfg_ready = ready;
   assign cfg.cfg_err   = err_q;

   assign hdata       = hcnt;
   assign vdata       = vcnt;
   assign running     = active;
   assign hsync       = (active && (act.hfp <= hcnt) && (hcnt < act.hsp)) ? HS_ON : !HS_ON;
   assign vsync       = (active && (act.vfp <= vcnt) && (vcnt < act.vsp)) ? VS_ON : !VS_ON;
   assign blank       = !(active && (hcnt < act.hsize) && (vcnt < act.vsize));
   assign line_start  = active && en && (hcnt == '0);
   assign frame_start = line_start && (vcnt == '0);

`ifdef VGA_GEN_FRAME_CNT_EN
   logic [15:0] fcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt <= '0;
      end else if (frame_end) begin
         fcnt <= fcnt + 16'd1;
      end
   end

   assign frame_cnt = fcnt;
`endif

endmodule

// File: tb/tb_vga_gen.sv
// Self-checking bench for vga_gen: legality table, directed corner sequences and a
// randomized run, all checked every cycle against a linear-pixel-index reference model.
module tb_vga_gen;
   localparam int WIDTH = 11;
   localparam int HSPP  = 0;
   localparam int VSPP  = 0;
   localparam bit HS_ON = (HSPP != 0);
   localparam bit VS_ON = (VSPP != 0);

   logic             clk = 1'b0;
   logic             rst, en;
   logic [WIDTH-1:0] hdata, vdata;
   logic             hsync, vsync, blank, line_start, frame_start, running;
`ifdef VGA_GEN_FRAME_CNT_EN
   logic [15:0]      frame_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   vga_gen_if #(.WIDTH(WIDTH)) bus ();

   vga_gen #(.WIDTH(WIDTH), .HSPP(HSPP), .VSPP(VSPP)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg(bus),
      .hdata(hdata), .vdata(vdata), .hsync(hsync), .vsync(vsync), .blank(blank),
      .line_start(line_start), .frame_start(frame_start), .running(running)
`ifdef VGA_GEN_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: mode 0 idle, 1 running, 2 running with a pending set.
   // Timing index: 0 hsize, 1 hfp, 2 hsp, 3 hmax, 4 vsize, 5 vfp, 6 vsp, 7 vmax.
   int          m_mode = 0;
   int unsigned at[8] = '{default: 0};
   int unsigned sh[8] = '{default: 0};
   int unsigned tm[8];
   int unsigned mh = 0, mv = 0, m_fc = 0;
   bit          m_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit xfer, legal, fend;
      int unsigned lin;
      if (rst) begin
         m_mode = 0; at = '{default: 0}; sh = '{default: 0};
         mh = 0; mv = 0; m_err = 1'b0; m_fc = 0;
         return;
      end
      tm[0] = bus.cfg_hsize; tm[1] = bus.cfg_hfp; tm[2] = bus.cfg_hsp; tm[3] = bus.cfg_hmax;
      tm[4] = bus.cfg_vsize; tm[5] = bus.cfg_vfp; tm[6] = bus.cfg_vsp; tm[7] = bus.cfg_vmax;
      xfer  = bus.cfg_valid && (m_mode != 2);
      legal = tm[0] <= tm[1] && tm[1] <= tm[2] && tm[2] <= tm[3] && tm[3] >= 2 &&
              tm[4] <= tm[5] && tm[5] <= tm[6] && tm[6] <= tm[7] && tm[7] >= 2;
      fend  = (m_mode != 0) && en && mh == at[3] - 1 && mv == at[7] - 1;
      m_err = xfer && !legal;
      if (m_mode != 0 && en) begin
         lin = mv * at[3] + mh + 1;
         if (lin == at[3] * at[7]) lin = 0;
         mh = lin % at[3];
         mv = lin / at[3];
      end
      if (fend) m_fc = (m_fc + 1) % 65536;
      if (m_mode == 0 && xfer && legal) begin
         at = tm; m_mode = 1; mh = 0; mv = 0;
      end else if (m_mode == 1 && xfer && legal) begin
         sh = tm; m_mode = 2;
      end else if (m_mode == 2 && fend) begin
         at = sh; m_mode = 1;
      end
   endtask

   task automatic check_all();
      bit run, ls;
      run = (m_mode != 0);
      ls  = run && en && mh == 0;
      chk("hdata", hdata, mh);
      chk("vdata", vdata, mv);
      chk("hsync", hsync, (run && at[1] <= mh && mh < at[2]) ? HS_ON : !HS_ON);
      chk("vsync", vsync, (run && at[5] <= mv && mv < at[6]) ? VS_ON : !VS_ON);
      chk("blank", blank, !(run && mh < at[0] && mv < at[4]));
      chk("line_start", line_start, ls);
      chk("frame_start", frame_start, ls && mv == 0);
      chk("running", running, run);
      chk("cfg_ready", bus.cfg_ready, m_mode != 2);
      chk("cfg_err", bus.cfg_err, m_err);
`ifdef VGA_GEN_FRAME_CNT_EN
      chk("frame_cnt", frame_cnt, m_fc);
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive_set(input int unsigned hs, hf, hp, hm, vs, vf, vp, vm);
      bus.cfg_hsize = WIDTH'(hs); bus.cfg_hfp = WIDTH'(hf);
      bus.cfg_hsp   = WIDTH'(hp); bus.cfg_hmax = WIDTH'(hm);
      bus.cfg_vsize = WIDTH'(vs); bus.cfg_vfp = WIDTH'(vf);
      bus.cfg_vsp   = WIDTH'(vp); bus.cfg_vmax = WIDTH'(vm);
   endtask

   task automatic wait_pos(input int unsigned h, input int unsigned v, input int budget);
      int k = 0;
      while (!(hdata == WIDTH'(h) && vdata == WIDTH'(v)) && k < budget) begin
         cycle();
         k++;
      end
      chk($sformatf("wait_pos_%0d_%0d", h, v), {hdata == WIDTH'(h), vdata == WIDTH'(v)}, 2'b11);
   endtask

   typedef struct {
      int unsigned hs, hf, hp, hm, vs, vf, vp, vm;
      bit          exp_err;
   } lvec_t;

   lvec_t lv[11];

   initial begin
      lv[0]  = '{6, 7, 8, 10, 2, 3, 4, 4, 1'b0};
      lv[1]  = '{6, 5, 8, 10, 2, 3, 4, 4, 1'b1};
      lv[2]  = '{0, 0, 0, 2, 0, 0, 0, 2, 1'b0};
      lv[3]  = '{0, 0, 0, 1, 0, 0, 0, 2, 1'b1};
      lv[4]  = '{0, 0, 0, 2, 0, 0, 0, 1, 1'b1};
      lv[5]  = '{10, 10, 10, 10, 4, 4, 4, 4, 1'b0};
      lv[6]  = '{6, 7, 11, 10, 2, 3, 4, 4, 1'b1};
      lv[7]  = '{2, 3, 4, 4, 3, 2, 4, 4, 1'b1};
      lv[8]  = '{2, 3, 4, 4, 1, 1, 1, 5, 1'b0};
      lv[9]  = '{1, 2, 3, 2047, 1, 2, 3, 2047, 1'b0};
      lv[10] = '{0, 0, 5, 4, 0, 0, 0, 2, 1'b1};

      rst = 1'b1; en = 1'b0; bus.cfg_valid = 1'b0;
      drive_set(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(); cycle();
      chk("rst_ready", bus.cfg_ready, 1'b1);
      chk("rst_running", running, 1'b0);
      chk("rst_blank", blank, 1'b1);
      chk("rst_hsync", hsync, !HS_ON);

      // Legality table, each offered from IDLE
      foreach (lv[i]) begin
         rst = 1'b1; bus.cfg_valid = 1'b0; cycle();
         rst = 1'b0; en = 1'b1; bus.cfg_valid = 1'b1;
         drive_set(lv[i].hs, lv[i].hf, lv[i].hp, lv[i].hm, lv[i].vs, lv[i].vf, lv[i].vp, lv[i].vm);
         cycle();
         bus.cfg_valid = 1'b0;
         chk($sformatf("tbl_err[%0d]", i), bus.cfg_err, lv[i].exp_err);
         chk($sformatf("tbl_run[%0d]", i), running, !lv[i].exp_err);
         cycle();
         chk($sformatf("tbl_err_clr[%0d]", i), bus.cfg_err, 1'b0);
      end

      // Basic frame with hmax=10, vmax=4
      rst = 1'b1; cycle();
      rst = 1'b0; en = 1'b1; bus.cfg_valid = 1'b1;
      drive_set(6, 7, 8, 10, 2, 3, 4, 4);
      cycle();
      bus.cfg_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         chk("seq_h", hdata, k % 10);
         chk("seq_v", vdata, (k / 10) % 4);
         chk("seq_hsync", hsync, (k % 10) != 7);
         chk("seq_blank", blank, !((k % 10) < 6 && ((k / 10) % 4) < 2));
         cycle();
      end

      // Illegal set while running is rejected without disturbing timing
      drive_set(6, 5, 8, 10, 2, 3, 4, 4); bus.cfg_valid = 1'b1;
      cycle();
      bus.cfg_valid = 1'b0;
      chk("rej_err", bus.cfg_err, 1'b1);
      chk("rej_ready", bus.cfg_ready, 1'b1);
      chk("rej_h", hdata, 1);
      cycle();
      chk("rej_err_clr", bus.cfg_err, 1'b0);

      // Mid-frame swap to hmax=12 takes effect only after frame end
      wait_pos(3, 1, 60);
      drive_set(6, 7, 8, 12, 2, 3, 4, 4); bus.cfg_valid = 1'b1;
      cycle();
      bus.cfg_valid = 1'b0;
      chk("pend_ready", bus.cfg_ready, 1'b0);
      for (int k = 0; k < 60 && !(hdata == 9 && vdata == 3); k++) begin
         cycle();
         chk("pend_ready_hold", bus.cfg_ready, 1'b0);
         chk("pend_old_period", hdata < 10, 1'b1);
      end
      cycle();
      chk("swap_h0", hdata, 0);
      chk("swap_v0", vdata, 0);
      chk("swap_ready", bus.cfg_ready, 1'b1);
      repeat (10) cycle();
      chk("new_h10", hdata, 10);
      cycle();
      chk("new_h11", hdata, 11);
      cycle();
      chk("new_wrap_h", hdata, 0);
      chk("new_wrap_v", vdata, 1);

      // Enable low for three cycles at hdata=4
      wait_pos(4, 1, 20);
      en = 1'b0;
      repeat (3) begin
         cycle();
         chk("hold_h", hdata, 4);
         chk("hold_ls", line_start, 1'b0);
      end
      en = 1'b1;
      cycle();
      chk("resume_h", hdata, 5);

      // Reset while a set is pending
      drive_set(6, 7, 8, 10, 2, 3, 4, 4); bus.cfg_valid = 1'b1;
      cycle();
      bus.cfg_valid = 1'b0;
      wait_pos(3, 2, 40);
      chk("pre_rst_pend", bus.cfg_ready, 1'b0);
      rst = 1'b1; bus.cfg_valid = 1'b1;
      cycle();
      chk("prst_running", running, 1'b0);
      chk("prst_blank", blank, 1'b1);
      chk("prst_ready", bus.cfg_ready, 1'b1);
      chk("prst_h", hdata, 0);
      rst = 1'b0; bus.cfg_valid = 1'b0;
      cycle();
      chk("prst_idle", running, 1'b0);

`ifdef VGA_GEN_FRAME_CNT_EN
      rst = 1'b1; cycle();
      chk("fc_reset", frame_cnt, 0);
      rst = 1'b0; en = 1'b1; bus.cfg_valid = 1'b1;
      drive_set(6, 7, 8, 10, 2, 3, 4, 4);
      cycle();
      bus.cfg_valid = 1'b0;
      repeat (120) cycle();
      chk("fc_three", frame_cnt, 3);
      rst = 1'b1; cycle();
      chk("fc_cleared", frame_cnt, 0);
      rst = 1'b0;
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         int unsigned hm, hp, hf, hs, vm, vp, vf, vs;
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 3) != 0);
         bus.cfg_valid = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 9) < 7) begin
            hm = $urandom_range(2, 12); hp = $urandom_range(0, hm);
            hf = $urandom_range(0, hp); hs = $urandom_range(0, hf);
            vm = $urandom_range(2, 6);  vp = $urandom_range(0, vm);
            vf = $urandom_range(0, vp); vs = $urandom_range(0, vf);
            drive_set(hs, hf, hp, hm, vs, vf, vp, vm);
         end else begin
            drive_set($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
         end
         cycle();
      end

      rst = 1'b0; bus.cfg_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
